// File: rtl/instr_encoder.sv
// Request packer and issue sequencer: packs operation requests into 32-bit words,
// queues them in a FIFO and presents them to the core, stalling after mul/div.
module instr_encoder #(
  parameter int DEPTH    = 4,
  parameter int DIV_HOLD = 4,
  parameter int MUL_HOLD = 2
) (
  input  logic                         _clock,
  input  logic                         _reset,
  input  logic                         _req_valid,
  output logic                         _req_ready,
  input  logic [2:0]                   _req_op,
  input  logic [1:0]                   _req_src,
  input  logic [1:0]                   _req_dest,
  input  logic [24:0]                  _req_imm,
  output logic                         _instr_valid,
  input  logic                         _instr_ready,
  output logic [31:0]                  _instrucao,
  output logic                         _illegal,
  output logic [$clog2(DEPTH+1)-1:0]   _count,
  output logic                         _busy
);

  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int HOLD_MAX = (DIV_HOLD > MUL_HOLD) ? DIV_HOLD : MUL_HOLD;
  localparam int HW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [2:0]    OP_DIV = 3'b010;
  localparam logic [2:0]    OP_MUL = 3'b011;
  localparam logic [2:0]    OP_ILL = 3'b101;
  localparam logic [2:0]    OP_RD  = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            accept, push, pop;
  logic [31:0]     packed_word, head;
  logic [2:0]      head_op;

  // Both ports: a transfer happens on a rising edge where valid & ready are high;
  // a producer holds its payload stable while valid is high and ready is low.
  assign _req_ready  = (count < FULL);
  assign accept      = _req_valid & _req_ready;
  assign push        = accept & (_req_op != OP_ILL);
  assign pop         = _instr_valid & _instr_ready;

  // Destination field is only meaningful for memory read.
  assign packed_word = {_req_op, _req_src, (_req_op == OP_RD) ? _req_dest : 2'b00, _req_imm};
  assign head        = mem[rd_ptr];
  assign head_op     = head[31:29];

  always_ff @(posedge _clock) begin
    if (push) mem[wr_ptr] <= packed_word;
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      hold_cnt <= '0;
      _illegal <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      _illegal <= accept & (_req_op == OP_ILL);
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    _instr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = PRESENT;
      end
      PRESENT: begin
        _instr_valid = 1'b1;
        if (_instr_ready) begin
          if (head_op == OP_DIV && DIV_HOLD > 0) begin
            state_nxt = HOLD;
            hold_nxt  = HW'(DIV_HOLD);
          end else if (head_op == OP_MUL && MUL_HOLD > 0) begin
            state_nxt = HOLD;
            hold_nxt  = HW'(MUL_HOLD);
          end else if (count > CW'(1) || push) begin
            state_nxt = PRESENT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        // The last stall cycle is the one where the counter reads 1.
        hold_nxt = hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) state_nxt = (count != '0) ? PRESENT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  assign _instrucao = _instr_valid ? head : 32'h0;
  assign _count     = count;
  assign _busy      = (count != '0) || (state == HOLD);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus a randomized run checked
// against a queue-based model of the packing, occupancy and stall rules.
module tb_instr_encoder;

  localparam int DEPTH    = 4;
  localparam int DIV_HOLD = 4;
  localparam int MUL_HOLD = 2;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [1:0]    req_src = '0;
  logic [1:0]    req_dest = '0;
  logic [24:0]   req_imm = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instrucao;
  logic          illegal;
  logic [CW-1:0] count;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .DIV_HOLD(DIV_HOLD), .MUL_HOLD(MUL_HOLD)) dut (
    ._clock(clk), ._reset(rst),
    ._req_valid(req_valid), ._req_ready(req_ready),
    ._req_op(req_op), ._req_src(req_src), ._req_dest(req_dest), ._req_imm(req_imm),
    ._instr_valid(instr_valid), ._instr_ready(instr_ready), ._instrucao(instrucao),
    ._illegal(illegal), ._count(count), ._busy(busy)
  );

  // Word layout computed arithmetically from the field positions.
  function automatic logic [31:0] pack(input int op, input int src, input int dest, input int imm);
    longint w;
    w = longint'(op % 8) * (64'd1 << 29) + longint'(src % 4) * (64'd1 << 27)
      + ((op % 8 == 6) ? longint'(dest % 4) * (64'd1 << 25) : 64'd0) + longint'(imm % (1 << 25));
    return 32'(w);
  endfunction

  function automatic int hold_for(input logic [31:0] w);
    int op;
    op = int'(w / 32'h2000_0000);
    if (op == 2) return DIV_HOLD;
    if (op == 3) return MUL_HOLD;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int op, input int src, input int dest, input int imm);
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_src   = 2'(src);
    req_dest  = 2'(dest);
    req_imm   = 25'(imm);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
    total++; if (instrucao !== 32'h0) begin bad++; $display("FAIL reset_instrucao got=%h exp=0", instrucao); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b exp=0", illegal); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid;
    bit seen;
    int issued;
    instr_ready = 1'b0;
    push_req(3, 0, 0, 3);
    push_req(0, 1, 0, 11);
    push_req(0, 2, 0, 12);
    push_req(0, 3, 0, 13);
    instr_ready = 1'b1;
    wait_valid(seen);
    @(posedge clk);
    #1;
    total++; if (count !== CW'(3) || busy !== 1'b1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_setup count=%0d busy=%0b valid=%0b exp count=3 busy=1 valid=0", count, busy, instr_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_req_ready got=%0b exp=1", req_ready); end
    total++; if (instr_valid !== 1'b0 || instrucao !== 32'h0) begin bad++; $display("FAIL midreset_instr valid=%0b word=%h exp 0/0", instr_valid, instrucao); end
    total++; if (count !== '0 || busy !== 1'b0 || illegal !== 1'b0) begin
      bad++; $display("FAIL midreset_state count=%0d busy=%0b illegal=%0b exp all 0", count, busy, illegal);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) issued++;
    end
    total++; if (issued != 0) begin bad++; $display("FAIL midreset_no_issue got=%0d words exp=0", issued); end
    @(posedge clk);
    #1 instr_ready = 1'b0;
  endtask

  task automatic test_encoding;
    bit seen;
    instr_ready = 1'b1;
    push_req(0, 2, 3, 5);
    wait_valid(seen);
    total++; if (!seen || instrucao !== 32'h1000_0005) begin bad++; $display("FAIL enc_add got=%h exp=10000005", instrucao); end
    @(posedge clk);
    #1;
    push_req(6, 1, 3, 32'h1F);
    wait_valid(seen);
    total++; if (!seen || instrucao !== 32'hCE00_001F) begin bad++; $display("FAIL enc_memread got=%h exp=ce00001f", instrucao); end
    @(posedge clk);
    #1 instr_ready = 1'b0;
    idle(3);
  endtask

  task automatic test_stall;
    bit seen, seen2;
    int gap, exp_gap;
    logic [31:0] exp_word;
    for (int k = 0; k < 2; k++) begin
      exp_word = (k == 0) ? 32'h6000_0003 : 32'h5800_0007;
      exp_gap  = (k == 0) ? MUL_HOLD : DIV_HOLD;
      instr_ready = 1'b1;
      if (k == 0) push_req(3, 0, 0, 3);
      else        push_req(2, 3, 0, 7);
      push_req(0, 0, 0, 1);
      wait_valid(seen);
      total++; if (!seen || instrucao !== exp_word) begin bad++; $display("FAIL stall%0d_first got=%h exp=%h", k, instrucao, exp_word); end
      gap = 0;
      seen2 = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (instr_valid) begin
          seen2 = 1'b1;
          break;
        end
        gap++;
      end
      total++; if (gap != exp_gap) begin bad++; $display("FAIL stall%0d_gap got=%0d exp=%0d", k, gap, exp_gap); end
      total++; if (!seen2 || instrucao !== 32'h0000_0001) begin bad++; $display("FAIL stall%0d_second got=%h exp=00000001", k, instrucao); end
      @(posedge clk);
      #1 instr_ready = 1'b0;
      idle(3);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w;
    instr_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_op = 3'd0; req_src = 2'(i); req_dest = 2'd1; req_imm = 25'(16 + i);
      @(negedge clk);
      total++; if (req_ready !== (i < 4)) begin bad++; $display("FAIL bp_ready%0d got=%0b exp=%0b", i, req_ready, (i < 4)); end
      if (i < 4) exp_q.push_back(pack(0, i, 1, 16 + i));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    total++; if (count !== CW'(4)) begin bad++; $display("FAIL bp_count got=%0d exp=4", count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instrucao !== exp_q[0]) begin bad++; $display("FAIL bp_head_stable got=%h exp=%h", instrucao, exp_q[0]); end
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd0; req_src = 2'd0; req_dest = 2'd0; req_imm = 25'h55;
    exp_q.push_back(pack(0, 0, 0, 32'h55));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_pop_ready got=%0b exp=0", req_ready); end
      end
      if (k == 1) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_unblocked_ready got=%0b exp=1", req_ready); end
      end
      if (k == 2) begin
        total++; if (count !== CW'(3)) begin bad++; $display("FAIL bp_pushpop_count got=%0d exp=3", count); end
      end
      w = exp_q.pop_front();
      total++; if (instr_valid !== 1'b1 || instrucao !== w) begin bad++; $display("FAIL bp_drain%0d got=%h valid=%0b exp=%h", k, instrucao, instr_valid, w); end
      @(posedge clk);
      #1;
      if (k == 1) req_valid = 1'b0;
    end
    instr_ready = 1'b0;
    idle(2);
  endtask

  task automatic test_illegal;
    bit seen;
    instr_ready = 1'b0;
    push_req(0, 1, 0, 32'hA1);
    push_req(5, 2, 2, 32'hBEEF);
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%0b exp=1", illegal); end
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL illegal_count1 got=%0d exp=1", count); end
    push_req(0, 2, 0, 32'hA2);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end got=%0b exp=0", illegal); end
    total++; if (count !== CW'(2)) begin bad++; $display("FAIL illegal_count2 got=%0d exp=2", count); end
    instr_ready = 1'b1;
    wait_valid(seen);
    total++; if (!seen || instrucao !== pack(0, 1, 0, 32'hA1)) begin bad++; $display("FAIL illegal_add1 got=%h exp=%h", instrucao, pack(0, 1, 0, 32'hA1)); end
    @(posedge clk);
    #1;
    wait_valid(seen);
    total++; if (!seen || instrucao !== pack(0, 2, 0, 32'hA2)) begin bad++; $display("FAIL illegal_add2 got=%h exp=%h", instrucao, pack(0, 2, 0, 32'hA2)); end
    @(posedge clk);
    #1 instr_ready = 1'b0;
    idle(2);
  endtask

  task automatic test_wrap;
    logic [31:0] w;
    exp_q.delete();
    instr_ready = 1'b0;
    push_req(1, 1, 0, 100);
    exp_q.push_back(pack(1, 1, 0, 100));
    push_req(7, 2, 1, 101);
    exp_q.push_back(pack(7, 2, 1, 101));
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_op = 3'(i % 2); req_src = 2'(i); req_dest = 2'd3; req_imm = 25'(200 + i);
      instr_ready = 1'b1;
      @(negedge clk);
      total++; if (count !== CW'(2)) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=2", i, count); end
      w = exp_q.pop_front();
      total++; if (instr_valid !== 1'b1 || instrucao !== w) begin bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, instrucao, w); end
      exp_q.push_back(pack(i % 2, i, 3, 200 + i));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      total++; if (instr_valid !== 1'b1 || instrucao !== w) begin bad++; $display("FAIL wrap_tail%0d got=%h exp=%h", i, instrucao, w); end
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b0;
    idle(2);
  endtask

  task automatic test_random;
    int stall, wait_cnt, op;
    bit ill_pend, exp_ready;
    logic [31:0] w;
    stall = 0; wait_cnt = 0; ill_pend = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = $urandom_range(0, 7);
      req_valid   = ($urandom_range(0, 9) < 7);
      req_op      = 3'(op);
      req_src     = 2'($urandom_range(0, 3));
      req_dest    = 2'($urandom_range(0, 3));
      req_imm     = 25'($urandom);
      instr_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_ready = (exp_q.size() < DEPTH);
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c%0d got=%0b exp=%0b", cyc, req_ready, exp_ready); end
      total++; if (count !== CW'(exp_q.size())) begin bad++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cyc, count, exp_q.size()); end
      total++; if (illegal !== ill_pend) begin bad++; $display("FAIL rnd_illegal c%0d got=%0b exp=%0b", cyc, illegal, ill_pend); end
      total++; if (busy !== (exp_q.size() > 0 || stall > 0)) begin bad++; $display("FAIL rnd_busy c%0d got=%0b exp=%0b", cyc, busy, (exp_q.size() > 0 || stall > 0)); end
      if (instr_valid) begin
        wait_cnt = 0;
        total++; if (!(exp_q.size() > 0 && stall == 0 && instrucao === exp_q[0])) begin
          bad++; $display("FAIL rnd_issue c%0d got=%h stall=%0d queued=%0d", cyc, instrucao, stall, exp_q.size());
        end
      end else begin
        total++; if (instrucao !== 32'h0) begin bad++; $display("FAIL rnd_zero_word c%0d got=%h exp=0", cyc, instrucao); end
        if (exp_q.size() > 0 && stall == 0) wait_cnt++;
        else wait_cnt = 0;
        total++; if (wait_cnt > 1) begin bad++; $display("FAIL rnd_starved c%0d waited=%0d exp<=1", cyc, wait_cnt); end
      end
      if (instr_valid && instr_ready && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        stall = hold_for(w);
      end else if (stall > 0) begin
        stall--;
      end
      ill_pend = req_valid && exp_ready && (op == 5);
      if (req_valid && exp_ready && op != 5) exp_q.push_back(pack(op, int'(req_src), int'(req_dest), int'(req_imm)));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    instr_ready = 1'b1;
    idle(30);
    total++; if (count !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rnd_drain count=%0d busy=%0b exp 0/0", count, busy); end
    instr_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_encoding();
    test_stall();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
